mt_stream: RTL and testbench
============================

MT_STREAM -- requirements
Module: mt_stream

Interface
REQ-001 W, 32, output/state word width; legal values 32 (MT19937) and 64 (MT19937-64) only.
REQ-002 SEED_DEFAULT, 5489, seed applied automatically after reset.
REQ-003 N and M SHALL be derived from W, not exposed as parameters: N=624/M=397 for W=32, N=312/M=156 for W=64.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 seed  in  W  new seed value, sampled when seed_valid=1.
REQ-007 seed_valid  in  1  single-cycle request to re-seed; accepted in any state.
REQ-008 busy  out  1  high while the state array is being initialised.
REQ-009 rnd_data  out  W  tempered random word.
REQ-010 rnd_valid  out  1  rnd_data holds a valid word.
REQ-011 rnd_ready  in  1  consumer accepts rnd_data; a transfer occurs when rnd_valid=1 and rnd_ready=1.

Function
REQ-012 FSM states SHALL be INIT, FILL and RUN.
REQ-013 INIT: x[0] SHALL be loaded with the seed, index set to 1, and the FSM SHALL go to FILL.
REQ-014 FILL: one word per cycle, x[i] = f*(x[i-1] ^ (x[i-1] >> (W-2))) + i, mod 2^W; f=1812433253 (W=32) or 6364136223846793005 (W=64).
REQ-015 FILL SHALL last exactly N-1 cycles; after i=N-1 the FSM SHALL go to RUN with the generation index k=0.
REQ-016 RUN, per generated word: y = (x[k] upper bits above bit r) | (x[(k+1) mod N] lower r bits), with r=31 (W=32) or 31 (W=64).
REQ-017 RUN: x[k] SHALL be replaced by x[(k+M) mod N] ^ (y>>1) ^ (y[0] ? A : 0); A=0x9908B0DF (W=32) or 0xB5026F5AA96619E9 (W=64).
REQ-018 RUN: the tempered new x[k] SHALL be written to rnd_data, and k SHALL advance; N-1 wraps to 0.
REQ-019 Tempering: y^=(y>>u)&d; y^=(y<<s)&b; y^=(y<<t)&c; y^=y>>l.
REQ-020 Tempering constants for W=32: u=11, d=all-ones, s=7, b=0x9D2C5680, t=15, c=0xEFC60000, l=18.
REQ-021 Tempering constants for W=64: u=29, d=0x5555555555555555, s=17, b=0x71D67FFFEDA60000, t=37, c=0xFFF7EEE000000000, l=43.
REQ-022 A word SHALL be generated in a cycle only when the FSM is in RUN and (rnd_valid=0 or rnd_ready=1); throughput is 1 word/cycle.
REQ-023 A new word SHALL appear on rnd_data one cycle after it is generated; generation with no consumer SHALL stall.
REQ-024 While rnd_valid=1 and rnd_ready=0, rnd_data SHALL remain stable and neither x nor k SHALL change.
REQ-025 The first rnd_valid SHALL assert exactly N+1 cycles after the INIT cycle.
REQ-026 seed_valid=1 in any state SHALL take priority over all other activity in that cycle.
REQ-027 On seed_valid=1, the next cycle SHALL have FSM=INIT, rnd_valid=0 and any pending word discarded.
REQ-028 busy SHALL equal (FSM != RUN).
REQ-029 All arithmetic SHALL be modulo 2^W with no saturation.

Reset
REQ-030 When rst is asserted: FSM=INIT, seed register=SEED_DEFAULT, k=0, rnd_valid=0, rnd_data=0, busy=1.
REQ-031 The state array x SHALL NOT be reset; FILL SHALL fully overwrite it before any read.
REQ-032 Reset asserted mid-FILL or mid-RUN SHALL abandon the operation; after release the block SHALL reproduce the SEED_DEFAULT sequence from its first word.

Structure
REQ-033 Package mt_pkg SHALL hold the N, M, f, A, r and tempering constants per W, plus the FSM state enum.
REQ-034 Sub-module mt_temper SHALL be purely combinational, parametrised by W, and contain the tempering network only.
REQ-035 The state array SHALL be register-based, with three combinational read ports (k, k+1, k+M mod N) and one write port.

Verification
REQ-036 W=32, reset released, rnd_ready=1 -> first word 3499211612, 10000th word 4123659995.
REQ-037 W=64, reset released, rnd_ready=1 -> first word 14514284786278117030, 10000th word 9981545732273789042.
REQ-038 W=32, seed=5489 with seed_valid after 700 words -> busy for N cycles, then the sequence restarts at 3499211612.
REQ-039 W=32, rnd_ready toggled randomly -> the accepted-word stream SHALL be identical to the rnd_ready=1 stream, and rnd_data SHALL be stable during every stall.
REQ-040 W=32, rst pulsed at FILL index 300 and at RUN word 623 (k wrap) -> normal restart, first word 3499211612, no X on outputs.
REQ-041 W=32, seed_valid and a handshake in the same cycle -> the handshake completes but no new word appears, rnd_valid=0 next cycle.

Source files
------------

// File: rtl/mt_pkg.sv
// Mersenne Twister constants selected by word width, plus the stream FSM state type.
package mt_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } mt_state_e;

  // Split point between the upper and lower parts of the twist concatenation.
  localparam int unsigned MT_R = 31;

  function automatic int unsigned mt_n(input int unsigned w);
    return (w == 32'd64) ? 32'd312 : 32'd624;
  endfunction

  function automatic int unsigned mt_m(input int unsigned w);
    return (w == 32'd64) ? 32'd156 : 32'd397;
  endfunction

  function automatic logic [63:0] mt_f(input int unsigned w);
    return (w == 32'd64) ? 64'h5851_F42D_4C95_7F2D : 64'd1812433253;
  endfunction

  function automatic logic [63:0] mt_a(input int unsigned w);
    return (w == 32'd64) ? 64'hB502_6F5A_A966_19E9 : 64'h9908_B0DF;
  endfunction

  function automatic int unsigned mt_u(input int unsigned w);
    return (w == 32'd64) ? 32'd29 : 32'd11;
  endfunction

  function automatic logic [63:0] mt_d(input int unsigned w);
    return (w == 32'd64) ? 64'h5555_5555_5555_5555 : 64'hFFFF_FFFF;
  endfunction

  function automatic int unsigned mt_s(input int unsigned w);
    return (w == 32'd64) ? 32'd17 : 32'd7;
  endfunction

  function automatic logic [63:0] mt_b(input int unsigned w);
    return (w == 32'd64) ? 64'h71D6_7FFF_EDA6_0000 : 64'h9D2C_5680;
  endfunction

  function automatic int unsigned mt_t(input int unsigned w);
    return (w == 32'd64) ? 32'd37 : 32'd15;
  endfunction

  function automatic logic [63:0] mt_c(input int unsigned w);
    return (w == 32'd64) ? 64'hFFF7_EEE0_0000_0000 : 64'hEFC6_0000;
  endfunction

  function automatic int unsigned mt_l(input int unsigned w);
    return (w == 32'd64) ? 32'd43 : 32'd18;
  endfunction

endpackage

// File: rtl/mt_temper.sv
// Combinational Mersenne Twister tempering network.
module mt_temper
  import mt_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] y_i,
  output logic [W-1:0] z_o
);

  localparam int unsigned U = mt_u(W);
  localparam int unsigned S = mt_s(W);
  localparam int unsigned T = mt_t(W);
  localparam int unsigned L = mt_l(W);
  localparam logic [W-1:0] D = W'(mt_d(W));
  localparam logic [W-1:0] B = W'(mt_b(W));
  localparam logic [W-1:0] C = W'(mt_c(W));

  logic [W-1:0] t1;
  logic [W-1:0] t2;
  logic [W-1:0] t3;

  always_comb begin
    t1  = y_i ^ ((y_i >> U) & D);
    t2  = t1 ^ ((t1 << S) & B);
    t3  = t2 ^ ((t2 << T) & C);
    z_o = t3 ^ (t3 >> L);
  end

endmodule

// File: rtl/mt_stream.sv
// MT19937 / MT19937-64 word stream: seeds the state array one word per cycle,
// then twists and tempers one word per cycle behind a valid/ready handshake.
module mt_stream
  import mt_pkg::*;
#(
  parameter int unsigned    W            = 32,
  parameter logic [W-1:0]   SEED_DEFAULT = W'(5489)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] seed,
  input  logic         seed_valid,
  output logic         busy,
  output logic [W-1:0] rnd_data,
  output logic         rnd_valid,
  input  logic         rnd_ready
);

  localparam int unsigned N   = mt_n(W);
  localparam int unsigned M   = mt_m(W);
  localparam int unsigned IW  = $clog2(N);
  localparam int unsigned IW1 = IW + 1;
  localparam logic [W-1:0] F          = W'(mt_f(W));
  localparam logic [W-1:0] A          = W'(mt_a(W));
  localparam logic [W-1:0] LOWER_MASK = W'((64'd1 << MT_R) - 64'd1);
  localparam logic [W-1:0] UPPER_MASK = ~LOWER_MASK;

  if (W != 32 && W != 64) begin : g_bad_w
    $error("mt_stream: W must be 32 or 64");
  end

  mt_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0] seed_q, seed_d;
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;

  logic [W-1:0] x_q [N];

  logic [IW-1:0] k1;
  logic [IW-1:0] km;
  logic [IW:0]   km_sum;
  logic [IW-1:0] rd0_addr;
  logic [W-1:0]  x_rd0;
  logic [W-1:0]  fill_word;
  logic [W-1:0]  y;
  logic [W-1:0]  twist;
  logic [W-1:0]  tempered;
  logic          gen;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [W-1:0]  wr_data;

  // Read ports: FILL needs x[i-1]; RUN needs x[k], x[k+1], x[k+M] (all mod N).
  always_comb begin
    k1       = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
    km_sum   = {1'b0, idx_q} + IW1'(M);
    km       = (km_sum >= IW1'(N)) ? IW'(km_sum - IW1'(N)) : IW'(km_sum);
    rd0_addr = (state_q == ST_FILL) ? idx_q - IW'(1) : idx_q;
    x_rd0    = x_q[rd0_addr];
    fill_word = W'(F * (x_rd0 ^ (x_rd0 >> (W - 2)))) + W'(idx_q);
    y        = (x_rd0 & UPPER_MASK) | (x_q[k1] & LOWER_MASK);
    twist    = x_q[km] ^ (y >> 1) ^ (y[0] ? A : '0);
  end

  mt_temper #(.W(W)) u_temper (
    .y_i (twist),
    .z_o (tempered)
  );

  assign gen = (state_q == ST_RUN) && (!valid_q || rnd_ready) && !seed_valid;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seed_d  = seed_q;
    data_d  = data_q;
    valid_d = valid_q;
    wr_en   = 1'b0;
    wr_addr = idx_q;
    wr_data = fill_word;
    if (seed_valid) begin
      // Re-seed overrides everything, including a handshake in this cycle.
      state_d = ST_INIT;
      idx_d   = '0;
      seed_d  = seed;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          wr_en   = 1'b1;
          wr_addr = '0;
          wr_data = seed_q;
          idx_d   = IW'(1);
          state_d = ST_FILL;
        end
        ST_FILL: begin
          wr_en = 1'b1;
          if (idx_q == IW'(N - 1)) begin
            idx_d   = '0;
            state_d = ST_RUN;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        ST_RUN: begin
          if (valid_q && rnd_ready) begin
            valid_d = 1'b0;
          end
          if (gen) begin
            wr_en   = 1'b1;
            wr_data = twist;
            data_d  = tempered;
            valid_d = 1'b1;
            idx_d   = k1;
          end
        end
        default: begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      seed_q  <= SEED_DEFAULT;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seed_q  <= seed_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // State array is never reset; FILL overwrites every entry before RUN reads it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      x_q[wr_addr] <= wr_data;
    end
  end

  assign busy      = busy_q;
  assign rnd_data  = data_q;
  assign rnd_valid = valid_q;

endmodule

// File: tb/tb_mt_stream.sv
// Self-checking bench for mt_stream (W=32 and W=64 instances).
module tb_mt_stream;

  localparam int unsigned N = 624;

  localparam logic [31:0] W0 = 32'd3499211612;
  localparam logic [31:0] W1 = 32'd581869302;
  localparam logic [31:0] W2 = 32'd3890346734;
  localparam logic [31:0] W3 = 32'd3586334585;
  localparam logic [31:0] W4 = 32'd545404204;
  localparam logic [31:0] W5 = 32'd4161255391;
  localparam logic [31:0] W6 = 32'd3922919429;
  localparam logic [31:0] W7 = 32'd949333985;
  localparam logic [31:0] W8 = 32'd2715962298;
  localparam logic [31:0] W9 = 32'd1323567403;

  logic        clk;
  logic        rst;
  logic [31:0] seed;
  logic        seed_valid;
  logic        busy;
  logic [31:0] rnd_data;
  logic        rnd_valid;
  logic        rnd_ready;

  logic        rst64;
  logic [63:0] seed64;
  logic        sv64;
  logic        busy64;
  logic [63:0] data64;
  logic        valid64;
  logic        ready64;
  logic        done64;

  int checks;
  int errors;

  mt_stream #(.W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed       (seed),
    .seed_valid (seed_valid),
    .busy       (busy),
    .rnd_data   (rnd_data),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready)
  );

  mt_stream #(.W(64)) dut64 (
    .clk        (clk),
    .rst        (rst64),
    .seed       (seed64),
    .seed_valid (sv64),
    .busy       (busy64),
    .rnd_data   (data64),
    .rnd_valid  (valid64),
    .rnd_ready  (ready64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference MT19937 in the classic block-twist form.
  int unsigned mt_ref [624];
  int          mti;

  function automatic void ref_init(input int unsigned s);
    mt_ref[0] = s;
    for (int i = 1; i < 624; i++) begin
      mt_ref[i] = 32'(32'd1812433253 * (mt_ref[i-1] ^ (mt_ref[i-1] >> 30)) + 32'(i));
    end
    mti = 624;
  endfunction

  function automatic void ref_twist();
    int unsigned y;
    for (int i = 0; i < 624; i++) begin
      y = (mt_ref[i] & 32'h8000_0000) | (mt_ref[(i + 1) % 624] & 32'h7FFF_FFFF);
      mt_ref[i] = mt_ref[(i + 397) % 624] ^ (y >> 1) ^ ((y & 32'd1) != 0 ? 32'h9908_B0DF : 32'd0);
    end
    mti = 0;
  endfunction

  function automatic int unsigned ref_peek();
    int unsigned y;
    if (mti >= 624) ref_twist();
    y = mt_ref[mti];
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C_5680);
    y = y ^ ((y << 15) & 32'hEFC6_0000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // From reset release (or re-seed), first word must land N+1 cycles later.
  task automatic wait_first(input string name);
    int cnt;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!rnd_valid && cnt < 2 * N);
    check({name, "_latency"}, 64'(cnt), 64'(N + 1));
    check({name, "_word"}, 64'(rnd_data), 64'(W0));
  endtask

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int accepted;
    int cyc;
    int busy_cnt;

    tbl[0]  = '{1'b0, 1'b1, W0};
    tbl[1]  = '{1'b0, 1'b1, W0};
    tbl[2]  = '{1'b1, 1'b1, W1};
    tbl[3]  = '{1'b1, 1'b1, W2};
    tbl[4]  = '{1'b0, 1'b1, W2};
    tbl[5]  = '{1'b1, 1'b1, W3};
    tbl[6]  = '{1'b0, 1'b1, W3};
    tbl[7]  = '{1'b0, 1'b1, W3};
    tbl[8]  = '{1'b1, 1'b1, W4};
    tbl[9]  = '{1'b1, 1'b1, W5};
    tbl[10] = '{1'b1, 1'b1, W6};
    tbl[11] = '{1'b1, 1'b1, W7};
    tbl[12] = '{1'b1, 1'b1, W8};
    tbl[13] = '{1'b0, 1'b1, W8};
    tbl[14] = '{1'b1, 1'b1, W9};

    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    seed       = '0;
    seed_valid = 1'b0;
    rnd_ready  = 1'b0;
    repeat (2) tick();
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_valid", 64'(rnd_valid), 64'd0);
    check("rst_data", 64'(rnd_data), 64'd0);

    // Release reset and walk INIT/FILL into the first word.
    rst = 1'b0;
    for (int c = 1; c <= N + 1; c++) begin
      tick();
      if (c == 1)     check("init_busy", 64'(busy), 64'd1);
      if (c == N - 1) check("fill_busy", 64'(busy), 64'd1);
      if (c == N - 1) check("fill_valid", 64'(rnd_valid), 64'd0);
      if (c == N)     check("run_busy", 64'(busy), 64'd0);
      if (c == N)     check("run_valid_early", 64'(rnd_valid), 64'd0);
    end
    check("first_valid", 64'(rnd_valid), 64'd1);
    check("first_word", 64'(rnd_data), 64'(W0));

    for (int i = 0; i < 15; i++) begin
      rnd_ready = tbl[i].ready;
      tick();
      check($sformatf("tbl%0d_valid", i), 64'(rnd_valid), 64'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_data", i), 64'(rnd_data), 64'(tbl[i].exp_data));
    end

    // 10000th word with continuous ready.
    rnd_ready = 1'b1;
    reset_dut();
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 12000) begin
      tick();
      cyc++;
      if (rnd_valid) begin
        accepted++;
        if (accepted == 10000) check("word_10000", 64'(rnd_data), 64'd4123659995);
      end
    end
    if (accepted < 10000) fail_timeout("word_10000");

    // Random backpressure: every visible word must be the reference's next word.
    reset_dut();
    ref_init(32'd5489);
    accepted = 0;
    cyc = 0;
    while (accepted < 700 && cyc < 6000) begin
      tick();
      cyc++;
      rnd_ready = 1'($urandom_range(0, 1));
      if (rnd_valid) begin
        check("rand_word", 64'(rnd_data), 64'(ref_peek()));
        if (rnd_ready) begin
          mti++;
          accepted++;
        end
      end
    end
    if (accepted < 700) fail_timeout("rand_stream");

    // Re-seed in the same cycle as a completing handshake.
    rnd_ready  = 1'b1;
    seed       = 32'd5489;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    check("reseed_valid", 64'(rnd_valid), 64'd0);
    check("reseed_busy", 64'(busy), 64'd1);
    busy_cnt = 1;
    cyc = 0;
    while (busy && cyc < 2 * N) begin
      tick();
      cyc++;
      if (busy) busy_cnt++;
    end
    check("reseed_busy_cycles", 64'(busy_cnt), 64'(N));
    tick();
    check("reseed_first_valid", 64'(rnd_valid), 64'd1);
    check("reseed_first_word", 64'(rnd_data), 64'(W0));
    tick();
    check("reseed_second_word", 64'(rnd_data), 64'(W1));

    // Reset while FILL is at index 300.
    reset_dut();
    repeat (300) tick();
    check("midfill_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("midfill_rst_busy", 64'(busy), 64'd1);
    check("midfill_rst_valid", 64'(rnd_valid), 64'd0);
    tick();
    rst = 1'b0;
    wait_first("midfill");

    // Reset right after the k=623 word, i.e. at the index wrap.
    accepted = 1;
    cyc = 0;
    while (accepted < 624 && cyc < 2000) begin
      tick();
      cyc++;
      if (rnd_valid) accepted++;
    end
    if (accepted < 624) fail_timeout("midrun_words");
    rst = 1'b1;
    #1;
    check("midrun_rst_valid", 64'(rnd_valid), 64'd0);
    check("midrun_rst_data", 64'(rnd_data), 64'd0);
    check("midrun_rst_busy", 64'(busy), 64'd1);
    tick();
    rst = 1'b0;
    wait_first("midrun");

    cyc = 0;
    while (!done64 && cyc < 20000) begin
      tick();
      cyc++;
    end
    if (!done64) fail_timeout("w64_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // W=64 instance: continuous ready from reset.
  initial begin
    int cnt64;
    int cyc64;
    done64  = 1'b0;
    rst64   = 1'b1;
    seed64  = '0;
    sv64    = 1'b0;
    ready64 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst64 = 1'b0;
    cnt64 = 0;
    cyc64 = 0;
    while (cnt64 < 10000 && cyc64 < 12000) begin
      @(posedge clk);
      #1;
      cyc64++;
      if (valid64) begin
        cnt64++;
        if (cnt64 == 1)     check("w64_first", data64, 64'd14514284786278117030);
        if (cnt64 == 10000) check("w64_10000", data64, 64'd9981545732273789042);
      end
    end
    if (cnt64 < 10000) fail_timeout("w64_stream");
    done64 = 1'b1;
  end

endmodule
